// File: rtl/instruktions_abruf.sv
// Instruction fetch stage: holds the program counter, reads one instruction
// word per request over a request/ready handshake, hands it to the decoder
// with a one-cycle strobe, and handles jump redirects including stale
// in-flight reads.
module instruktions_abruf #(
  parameter logic [31:0] StartAdresse = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Weiter,
  input  logic        Sprung,
  input  logic [31:0] SprungZiel,
  input  logic        SpeicherBereit,
  input  logic [31:0] SpeicherDaten,
  output logic        SpeicherLesen,
  output logic [31:0] SpeicherAdresse,
  output logic [31:0] Instruktion,
  output logic        DekodierSignal,
  output logic [31:0] BefehlsAdresse
);

  // HOLEN latches the fetch address, WARTEN holds the request until the
  // memory answers, BEREIT parks until the control unit asks for more.
  typedef enum logic [1:0] {
    HOLEN  = 2'd0,
    WARTEN = 2'd1,
    BEREIT = 2'd2
  } zustand_t;

  zustand_t    zustand_q, zustand_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] anfrage_adresse_q, anfrage_adresse_d;
  logic        verwerfen_q, verwerfen_d;
  logic [31:0] instruktion_q, instruktion_d;
  logic [31:0] befehls_adresse_q, befehls_adresse_d;
  logic        dekodier_q, dekodier_d;
  logic        speicher_lesen;

  // Next-state, register updates and the read request, all from the current state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    zustand_d         = zustand_q;
    pc_d              = pc_q;
    anfrage_adresse_d = anfrage_adresse_q;
    verwerfen_d       = verwerfen_q;
    instruktion_d     = instruktion_q;
    befehls_adresse_d = befehls_adresse_q;
    dekodier_d        = 1'b0;
    speicher_lesen    = 1'b0;

    unique case (zustand_q)
      HOLEN: begin
        anfrage_adresse_d = pc_q;
        if (Sprung) begin
          pc_d              = SprungZiel;
          anfrage_adresse_d = SprungZiel;
        end
        zustand_d = WARTEN;
      end

      WARTEN: begin
        speicher_lesen = 1'b1;
        if (Sprung) pc_d = SprungZiel;
        if (SpeicherBereit) begin
          if (Sprung || verwerfen_q) begin
            // Answer belongs to a redirected stream: drop it and refetch.
            verwerfen_d = 1'b0;
            zustand_d   = HOLEN;
          end else begin
            instruktion_d     = SpeicherDaten;
            befehls_adresse_d = anfrage_adresse_q;
            pc_d              = anfrage_adresse_q + 32'd1;
            dekodier_d        = 1'b1;
            zustand_d         = BEREIT;
          end
        end else if (Sprung) begin
          // Read still in flight; remember to discard its answer.
          verwerfen_d = 1'b1;
        end
      end

      BEREIT: begin
        if (Sprung) pc_d = SprungZiel;
        if (Weiter) zustand_d = HOLEN;
      end

      default: zustand_d = HOLEN;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (Reset) begin
      zustand_q         <= HOLEN;
      pc_q              <= StartAdresse;
      anfrage_adresse_q <= StartAdresse;
      verwerfen_q       <= 1'b0;
      instruktion_q     <= 32'h0;
      befehls_adresse_q <= StartAdresse;
      dekodier_q        <= 1'b0;
    end else begin
      zustand_q         <= zustand_d;
      pc_q              <= pc_d;
      anfrage_adresse_q <= anfrage_adresse_d;
      verwerfen_q       <= verwerfen_d;
      instruktion_q     <= instruktion_d;
      befehls_adresse_q <= befehls_adresse_d;
      dekodier_q        <= dekodier_d;
    end
  end

  assign SpeicherLesen   = speicher_lesen;
  assign SpeicherAdresse = anfrage_adresse_q;
  assign Instruktion     = instruktion_q;
  assign DekodierSignal  = dekodier_q;
  assign BefehlsAdresse  = befehls_adresse_q;

endmodule

// File: tb/tb_instruktions_abruf.sv
// Directed bench for instruktions_abruf: a per-cycle vector table covering
// sequential fetch, wait states, jumps, wrap-around and reset, followed by a
// hand-written handshake sequence with bounded waits.
module tb_instruktions_abruf;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Weiter;
  logic        Sprung;
  logic [31:0] SprungZiel;
  logic        SpeicherBereit;
  logic [31:0] SpeicherDaten;
  logic        SpeicherLesen;
  logic [31:0] SpeicherAdresse;
  logic [31:0] Instruktion;
  logic        DekodierSignal;
  logic [31:0] BefehlsAdresse;

  int checks = 0;
  int errors = 0;

  instruktions_abruf #(.StartAdresse(32'h0000_0010)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Weiter         (Weiter),
    .Sprung         (Sprung),
    .SprungZiel     (SprungZiel),
    .SpeicherBereit (SpeicherBereit),
    .SpeicherDaten  (SpeicherDaten),
    .SpeicherLesen  (SpeicherLesen),
    .SpeicherAdresse(SpeicherAdresse),
    .Instruktion    (Instruktion),
    .DekodierSignal (DekodierSignal),
    .BefehlsAdresse (BefehlsAdresse)
  );

  always #5 Clock = ~Clock;

  // One cycle: inputs applied during it, outputs expected during it.
  typedef struct {
    logic        rst;
    logic        wei;
    logic        spr;
    logic [31:0] ziel;
    logic        ber;
    logic [31:0] dat;
    logic        e_les;
    logic [31:0] e_adr;
    logic        e_dek;
    logic [31:0] e_ins;
    logic [31:0] e_bef;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic wei, logic spr, logic [31:0] ziel,
                              logic ber, logic [31:0] dat, logic e_les,
                              logic [31:0] e_adr, logic e_dek, logic [31:0] e_ins,
                              logic [31:0] e_bef);
    vec_t v;
    v.rst = rst; v.wei = wei; v.spr = spr; v.ziel = ziel; v.ber = ber; v.dat = dat;
    v.e_les = e_les; v.e_adr = e_adr; v.e_dek = e_dek; v.e_ins = e_ins; v.e_bef = e_bef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    int n;

    //                 rst wei spr ziel          ber dat           les adr           dek ins           bef
    // Reset state and sequential zero-wait fetch from 0x10
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h10,        0, 32'h0,         32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0010, 1, 32'h10,        0, 32'h0,         32'h10));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h10,        1, 32'hA000_0010, 32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h10,        0, 32'hA000_0010, 32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0011, 1, 32'h11,        0, 32'hA000_0010, 32'h10));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h11,        1, 32'hA000_0011, 32'h11));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h11,        0, 32'hA000_0011, 32'h11));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0012, 1, 32'h12,        0, 32'hA000_0011, 32'h11));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h12,        1, 32'hA000_0012, 32'h12));
    // Parked in BEREIT without Weiter, then a fetch with four wait cycles
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h12,        0, 32'hA000_0012, 32'h12));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h12,        0, 32'hA000_0012, 32'h12));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h12,        0, 32'hA000_0012, 32'h12));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         1, 32'h13,        0, 32'hA000_0012, 32'h12));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h13,        0, 32'hA000_0012, 32'h12));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h13,        0, 32'hA000_0012, 32'h12));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h13,        0, 32'hA000_0012, 32'h12));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0013, 1, 32'h13,        0, 32'hA000_0012, 32'h12));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h13,        1, 32'hA000_0013, 32'h13));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h13,        0, 32'hA000_0013, 32'h13));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h13,        0, 32'hA000_0013, 32'h13));
    // Jump in BEREIT together with Weiter
    vq.push_back(mk(0, 1, 1, 32'h200,       0, 32'h0,         0, 32'h13,        0, 32'hA000_0013, 32'h13));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h13,        0, 32'hA000_0013, 32'h13));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0200, 1, 32'h200,       0, 32'hA000_0013, 32'h13));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h200,       1, 32'hA000_0200, 32'h200));
    // Fetch of 0x11, jump to 0x80 two cycles before the memory answers
    vq.push_back(mk(0, 1, 1, 32'h11,        0, 32'h0,         0, 32'h200,       0, 32'hA000_0200, 32'h200));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h200,       0, 32'hA000_0200, 32'h200));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h11,        0, 32'hA000_0200, 32'h200));
    vq.push_back(mk(0, 0, 1, 32'h80,        0, 32'h0,         1, 32'h11,        0, 32'hA000_0200, 32'h200));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h11,        0, 32'hA000_0200, 32'h200));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0011, 1, 32'h11,        0, 32'hA000_0200, 32'h200));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h11,        0, 32'hA000_0200, 32'h200));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0080, 1, 32'h80,        0, 32'hA000_0200, 32'h200));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h80,        1, 32'hA000_0080, 32'h80));
    // Jump in the same WARTEN cycle as the answer: dropped without a stale flag
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h80,        0, 32'hA000_0080, 32'h80));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h80,        0, 32'hA000_0080, 32'h80));
    vq.push_back(mk(0, 0, 1, 32'h40,        1, 32'hA000_0081, 1, 32'h81,        0, 32'hA000_0080, 32'h80));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h81,        0, 32'hA000_0080, 32'h80));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0040, 1, 32'h40,        0, 32'hA000_0080, 32'h80));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h40,        1, 32'hA000_0040, 32'h40));
    // Fetch at 0xFFFF_FFFF wraps to 0
    vq.push_back(mk(0, 1, 1, 32'hFFFF_FFFF, 0, 32'h0,         0, 32'h40,        0, 32'hA000_0040, 32'h40));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h40,        0, 32'hA000_0040, 32'h40));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 0, 32'hA000_0040, 32'h40));
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 32'hFFFF_FFFF));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hFFFF_FFFF, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFF));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'hDEAD_BEEF, 32'hFFFF_FFFF));
    // Reset in the middle of WARTEN, refetch from the start address
    vq.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0,         0, 32'hDEAD_BEEF, 32'hFFFF_FFFF));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h10,        0, 32'h0,         32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0010, 1, 32'h10,        0, 32'h0,         32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h10,        1, 32'hA000_0010, 32'h10));
    // Jump taken in HOLEN redirects the request immediately
    vq.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h10,        0, 32'hA000_0010, 32'h10));
    vq.push_back(mk(0, 0, 1, 32'h300,       0, 32'h0,         0, 32'h10,        0, 32'hA000_0010, 32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA000_0300, 1, 32'h300,       0, 32'hA000_0010, 32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h300,       1, 32'hA000_0300, 32'h300));

    Reset = 1'b1; Weiter = 1'b0; Sprung = 1'b0; SprungZiel = 32'h0;
    SpeicherBereit = 1'b0; SpeicherDaten = 32'h0;
    repeat (2) @(posedge Clock);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge Clock);
      Reset          = vq[i].rst;
      Weiter         = vq[i].wei;
      Sprung         = vq[i].spr;
      SprungZiel     = vq[i].ziel;
      SpeicherBereit = vq[i].ber;
      SpeicherDaten  = vq[i].dat;
      check($sformatf("v%0d_lesen", i),   32'(SpeicherLesen),  32'(vq[i].e_les));
      check($sformatf("v%0d_adresse", i), SpeicherAdresse,     vq[i].e_adr);
      check($sformatf("v%0d_strobe", i),  32'(DekodierSignal), 32'(vq[i].e_dek));
      check($sformatf("v%0d_instr", i),   Instruktion,         vq[i].e_ins);
      check($sformatf("v%0d_befadr", i),  BefehlsAdresse,      vq[i].e_bef);
    end

    // Handshake sequence: request next word (0x301), answer after two waits.
    @(negedge Clock);
    Reset = 1'b0; Sprung = 1'b0; SpeicherBereit = 1'b0; Weiter = 1'b1;
    @(negedge Clock);
    Weiter = 1'b0;
    n = 0;
    while (!SpeicherLesen && n < 8) begin
      @(negedge Clock);
      n++;
    end
    check("hs_request_seen", 32'(SpeicherLesen), 32'h1);
    check("hs_request_addr", SpeicherAdresse, 32'h301);
    repeat (2) begin
      @(negedge Clock);
      check("hs_wait_lesen", 32'(SpeicherLesen), 32'h1);
      check("hs_wait_addr", SpeicherAdresse, 32'h301);
      check("hs_wait_nostrobe", 32'(DekodierSignal), 32'h0);
    end
    SpeicherBereit = 1'b1;
    SpeicherDaten  = 32'h1234_5678;
    @(negedge Clock);
    SpeicherBereit = 1'b0;
    check("hs_strobe", 32'(DekodierSignal), 32'h1);
    check("hs_instr", Instruktion, 32'h1234_5678);
    check("hs_befadr", BefehlsAdresse, 32'h301);
    check("hs_lesen_off", 32'(SpeicherLesen), 32'h0);
    @(negedge Clock);
    check("hs_strobe_one_cycle", 32'(DekodierSignal), 32'h0);
    check("hs_no_rerequest", 32'(SpeicherLesen), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruktions_abruf.md
# instruktions_abruf

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and reads one 32-bit instruction word per request from instruction memory over a request/ready handshake. Delivers the word on `Instruktion` with a one-cycle `DekodierSignal` strobe, which the decoder uses to latch it. Handles jump redirects from the control unit and discards any in-flight fetch that a jump makes stale.

## Interface
- `StartAdresse`, default 32'h0000_0000: PC value after reset (word address).
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  reset, synchronous, active-high.
- `Weiter`  in  1  control unit requests the next instruction. Honoured only in state BEREIT.
- `Sprung`  in  1  jump redirect. Valid in any state.
- `SprungZiel`  in  32  jump target word address. Sampled when `Sprung`=1.
- `SpeicherBereit`  in  1  memory has data for the outstanding read.
- `SpeicherDaten`  in  32  read data. Valid when `SpeicherBereit`=1.
- `SpeicherLesen`  out  1  read request. Held high until `SpeicherBereit`.
- `SpeicherAdresse`  out  32  read word address. Stable while `SpeicherLesen`=1.
- `Instruktion`  out  32  last fetched instruction word (to decoder).
- `DekodierSignal`  out  1  one-cycle strobe: `Instruktion` is new (to decoder).
- `BefehlsAdresse`  out  32  word address of the word on `Instruktion`, used as base for relative jumps.

## Operation
- Internal registers:
  - `PC` (32): next address to fetch.
  - `AnfrageAdresse` (32): address of the outstanding request.
  - `Verwerfen` (1): the outstanding request is stale.
  - State register.
- State HOLEN:
  - `AnfrageAdresse <= PC`.
  - If `Sprung`=1, load `SprungZiel` into both `PC` and `AnfrageAdresse`.
  - Next state: WARTEN.
- State WARTEN:
  - `SpeicherLesen`=1 and `SpeicherAdresse`=`AnfrageAdresse`.
  - On `SpeicherBereit`=1 with `Verwerfen`=0:
    - `Instruktion <= SpeicherDaten`.
    - `BefehlsAdresse <= AnfrageAdresse`.
    - `PC <= AnfrageAdresse + 1`.
    - `DekodierSignal <= 1`.
    - Next state: BEREIT.
  - On `SpeicherBereit`=1 with `Verwerfen`=1:
    - Drop the data; `Instruktion`, `BefehlsAdresse` and `DekodierSignal` are unchanged.
    - Clear `Verwerfen`. Next state: HOLEN.
  - `Sprung` in WARTEN:
    - `PC <= SprungZiel`.
    - If `SpeicherBereit`=0 in the same cycle, set `Verwerfen`.
    - If `SpeicherBereit`=1 in the same cycle, drop the data directly and go to HOLEN; `Verwerfen` stays 0.
- State BEREIT:
  - `Sprung`=1 gives `PC <= SprungZiel`, with or without `Weiter`.
  - `Weiter`=1 gives next state HOLEN.
  - Without `Weiter`, stay in BEREIT indefinitely.
- `Weiter` in HOLEN or WARTEN is ignored, not queued.
- `DekodierSignal` is registered and high for exactly one cycle per accepted word.
- `PC` arithmetic is modulo 2^32: 32'hFFFF_FFFF + 1 = 0.
- Jump arithmetic: `SprungZiel` is an absolute address. Relative targets are computed outside this block.
- Reset values:
  - `PC` and `AnfrageAdresse` = `StartAdresse`.
  - State = HOLEN, `Verwerfen` = 0.
  - `Instruktion` = 0, `DekodierSignal` = 0, `BefehlsAdresse` = `StartAdresse`.
  - `SpeicherLesen` = 0 (combinational from state, so 0 in HOLEN).
- Reset during WARTEN abandons the request: `SpeicherLesen` is 0 from the cycle after the reset edge. The memory drops abandoned requests.

## Timing
- After `Reset` deasserts: HOLEN in cycle 0, WARTEN in cycle 1 (`SpeicherLesen`=1).
- With zero-wait memory (`SpeicherBereit` high in the first WARTEN cycle), `DekodierSignal`=1 in cycle 2.
- `Weiter` sampled at edge n: HOLEN in cycle n+1, WARTEN in n+2, strobe in n+3 plus the memory wait cycles.
- The decoder latches `Instruktion` on the edge that ends the strobe cycle.
- Jump cost: a jump during WARTEN adds the remaining wait cycles plus one full refetch.
- Fetch throughput is at most one instruction per 3 cycles (HOLEN, WARTEN, BEREIT).

## Test plan
- Sequential fetch:
  - Stimulus: `StartAdresse`=0x10, memory returns 0xA000_0000 + address with zero wait; `Weiter` pulsed on each strobe.
  - Required: strobes every 3 cycles, carrying 0xA000_0010, 0xA000_0011, 0xA000_0012; `BefehlsAdresse` 0x10, 0x11, 0x12.
- Wait states:
  - Stimulus: `SpeicherBereit` delayed 4 cycles.
  - Required: `SpeicherLesen` high for 5 cycles with `SpeicherAdresse` constant; single strobe; no second request without `Weiter`.
- Jump in BEREIT:
  - Stimulus: `Sprung`=1, `SprungZiel`=0x200, together with `Weiter`.
  - Required: next request address 0x200; next `BefehlsAdresse`=0x200.
- Jump during WARTEN:
  - Stimulus: fetch of 0x11 outstanding; `Sprung` to 0x80 two cycles before `SpeicherBereit`.
  - Required: data for 0x11 dropped with no strobe; new request at 0x80; strobe carries word 0x80.
- Wrap and reset:
  - Stimulus: fetch at 0xFFFF_FFFF.
  - Required: next request at 0x0000_0000.
  - Stimulus: assert `Reset` mid-WARTEN.
  - Required: next cycle `SpeicherLesen`=0, `DekodierSignal`=0, `Instruktion`=0; refetch starts from `StartAdresse`.
